// File: rtl/adi_tala_beat_tracker.sv
// Recovers the 8-beat Adi tala cycle from the LED generator's led[1:0] half-beat pulses:
// beat index, locked beat period, completed-cycle count and a pattern-violation pulse.
//
//  state  | meaning
//  HUNT   | waiting for an led[0] onset that follows an led[1] onset (candidate beat 0)
//  SYNC   | beat 0 seen; next led[0] onset gives the beat period
//  LOCKED | tracking beats 1..7,0 with exact interval match
module adi_tala_beat_tracker #(
   parameter int PW = 8,
   parameter int CW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    led_in,
   output logic          beat_strobe,
   output logic [2:0]    beat_idx,
   output logic [CW-1:0] cycle_count,
   output logic [PW-1:0] period,
   output logic          locked,
   output logic          pattern_err
);

   typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

   state_t        state, state_n;
   logic [1:0]    led_q;
   logic [PW-1:0] ivl, ivl_n;
   logic          last_b1, last_b1_n;
   logic [2:0]    idx_n, idx_inc;
   logic [CW-1:0] cc_n;
   logic [PW-1:0] per_n;
   logic          strobe_n, err_n, beat_ok;
   logic          r0, r1, onset;
   logic [PW:0]   m, per_x, per2;

   assign r0      = led_in[0] & ~led_q[0];
   assign r1      = led_in[1] & ~led_q[1];
   assign onset   = r0 | r1;
   assign m       = {1'b0, ivl} + {{PW{1'b0}}, 1'b1};
   assign per_x   = {1'b0, period};
   assign per2    = {period, 1'b0};
   assign idx_inc = beat_idx + 3'd1;

   always_comb begin
      ivl_n = onset ? '0 : ((ivl == {PW{1'b1}}) ? ivl : ivl + PW'(1));
   end

   always_comb begin
      state_n   = state;
      idx_n     = beat_idx;
      cc_n      = cycle_count;
      per_n     = period;
      last_b1_n = last_b1;
      strobe_n  = 1'b0;
      err_n     = 1'b0;
      beat_ok   = 1'b0;
      if (r0 && r1) begin
         err_n   = 1'b1;
         state_n = HUNT;
      end else begin
         if (onset) last_b1_n = r1;
         case (state)
            HUNT: begin
               if (r0 && last_b1) begin
                  idx_n    = 3'd0;
                  strobe_n = 1'b1;
                  state_n  = SYNC;
               end
            end
            SYNC: begin
               if (r0) begin
                  per_n    = m[PW] ? {PW{1'b1}} : m[PW-1:0];
                  idx_n    = 3'd1;
                  strobe_n = 1'b1;
                  state_n  = LOCKED;
               end else if (r1) begin
                  err_n   = 1'b1;
                  state_n = HUNT;
               end
            end
            LOCKED: begin
               if (!onset) begin
                  // Beat 7 is silent: it is inferred purely from elapsed time.
                  if (beat_idx == 3'd6 && m == per_x) begin
                     idx_n    = 3'd7;
                     strobe_n = 1'b1;
                  end else if (m > per2) begin
                     err_n   = 1'b1;
                     state_n = HUNT;
                  end
               end else begin
                  case (beat_idx)
                     3'd0, 3'd1, 3'd2: beat_ok = r0 && (m == per_x);
                     3'd3, 3'd4, 3'd5: beat_ok = r1 && (m == per_x);
                     3'd7:             beat_ok = r0 && (m == per2);
                     default:          beat_ok = 1'b0;
                  endcase
                  if (beat_ok) begin
                     idx_n    = idx_inc;
                     strobe_n = 1'b1;
                     if (beat_idx == 3'd7) cc_n = cycle_count + CW'(1);
                  end else begin
                     err_n   = 1'b1;
                     state_n = HUNT;
                  end
               end
            end
            default: state_n = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= HUNT;
         led_q       <= 2'b00;
         ivl         <= '0;
         beat_idx    <= 3'd0;
         cycle_count <= '0;
         period      <= '0;
         last_b1     <= 1'b0;
         beat_strobe <= 1'b0;
         locked      <= 1'b0;
         pattern_err <= 1'b0;
      end else begin
         state       <= state_n;
         led_q       <= led_in;
         ivl         <= ivl_n;
         beat_idx    <= idx_n;
         cycle_count <= cc_n;
         period      <= per_n;
         last_b1     <= last_b1_n;
         beat_strobe <= strobe_n;
         locked      <= (state_n == LOCKED);
         pattern_err <= err_n;
      end
   end

endmodule

// File: tb/tb_adi_tala_beat_tracker.sv
// Scoreboarded bench for adi_tala_beat_tracker: a generator-like driver pushes expected
// beat/error events; a negedge monitor pops and compares whenever the DUT pulses.
module tb_adi_tala_beat_tracker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] led_in = 2'b00;

   logic       bs1, le1, pe1, bs2, le2, pe2;
   logic [2:0] bi1, bi2;
   logic [9:0] cc1;
   logic [1:0] cc2;
   logic [7:0] pr1, pr2;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int exp_cc = 0;
   int exp_per = 0;

   typedef struct {
      int err;
      int idx;
      int cc;
      int per;
      int lk;
      int t;
   } ev_t;

   ev_t q[$];

   adi_tala_beat_tracker #(.PW(8), .CW(10)) dut (
      .clk(clk), .rst(rst), .led_in(led_in), .beat_strobe(bs1), .beat_idx(bi1),
      .cycle_count(cc1), .period(pr1), .locked(le1), .pattern_err(pe1));

   adi_tala_beat_tracker #(.PW(8), .CW(2)) dut2 (
      .clk(clk), .rst(rst), .led_in(led_in), .beat_strobe(bs2), .beat_idx(bi2),
      .cycle_count(cc2), .period(pr2), .locked(le2), .pattern_err(pe2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input int act, input int exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", nm, act, exp_v, cyc);
      end
   endfunction

   function automatic void push(input int err, input int idx, input int lk, input int t);
      ev_t e;
      e.err = err; e.idx = idx; e.cc = exp_cc; e.per = exp_per; e.lk = lk; e.t = t;
      q.push_back(e);
   endfunction

   always @(negedge clk) begin
      ev_t e;
      if (!rst && (bs1 || pe1)) begin
         if (q.size() == 0) begin
            chk("unexpected_event", 1, 0);
         end else begin
            e = q.pop_front();
            chk("ev_time", cyc, e.t);
            chk("ev_strobe", int'(bs1), (e.err != 0) ? 0 : 1);
            chk("ev_err", int'(pe1), e.err);
            chk("ev_idx", int'(bi1), e.idx);
            chk("ev_cc", int'(cc1), e.cc % 1024);
            chk("ev_period", int'(pr1), e.per);
            chk("ev_locked", int'(le1), e.lk);
            chk("ev_cc_cw2", int'(cc2), e.cc % 4);
         end
      end
   end

   // One beat: half-beat pulse on the selected LED (k=0 led0, k=1 led1, k=2 silent).
   task automatic drive_beat(input int p, input int k);
      for (int i = 0; i < p; i++) begin
         if (k < 2 && i < p / 2) led_in = (k == 0) ? 2'b01 : 2'b10;
         else                    led_in = 2'b00;
         @(posedge clk); #1;
      end
   endtask

   // mode 0: hunting (no events), 1: acquisition cycle, 2: locked cycle.
   task automatic run_cycle(input int p, input int mode, output int oc6);
      int oc;
      oc6 = 0;
      for (int b = 0; b < 8; b++) begin
         oc = cyc;
         if (b == 7) begin
            if (mode != 0) push(0, 7, 1, oc6 + 1 + p);
            drive_beat(p, 2);
         end else begin
            if (mode == 2 && b == 0) exp_cc++;
            if (mode == 1 && b == 1) exp_per = p;
            if (mode != 0) push(0, b, (mode == 2 || b > 0) ? 1 : 0, oc + 1);
            if (b == 6) oc6 = oc;
            drive_beat(p, (b < 4) ? 0 : 1);
         end
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_strobe"}, int'(bs1), 0);
      chk({tag, "_idx"}, int'(bi1), 0);
      chk({tag, "_cc"}, int'(cc1), 0);
      chk({tag, "_period"}, int'(pr1), 0);
      chk({tag, "_locked"}, int'(le1), 0);
      chk({tag, "_err"}, int'(pe1), 0);
   endtask

   task automatic do_reset(input string tag);
      chk({tag, "_pending_events"}, q.size(), 0);
      rst = 1'b1;
      led_in = 2'b00;
      @(posedge clk); @(posedge clk); #1;
      check_zero(tag);
      rst = 1'b0;
      exp_cc = 0;
      exp_per = 0;
   endtask

   initial begin
      int oc6, s0, oc;

      // Test 1: lock at period 10, then clean cycles (also drives the CW=2 wrap).
      do_reset("rst1");
      s0 = cyc;
      run_cycle(10, 0, oc6);
      run_cycle(10, 1, oc6);
      chk("t1_lock_start_rel", q.size(), 0);
      run_cycle(10, 2, oc6);
      run_cycle(10, 2, oc6);
      chk("t1_elapsed", cyc - s0, 320);

      // Test 3: speed change mid-beat 2 -> one error, relock at period 4, count held.
      exp_cc++;
      oc = cyc; push(0, 0, 1, oc + 1); drive_beat(10, 0);
      oc = cyc; push(0, 1, 1, oc + 1); drive_beat(10, 0);
      oc = cyc; push(0, 2, 1, oc + 1); drive_beat(7, 0);
      oc = cyc; push(1, 2, 0, oc + 1); drive_beat(4, 0);
      for (int b = 4; b < 7; b++) drive_beat(4, 1);
      drive_beat(4, 2);
      run_cycle(4, 1, oc6);
      for (int c = 0; c < 3; c++) run_cycle(4, 2, oc6);
      chk("t3_final_cc", int'(cc1), 6);

      // Test 4: silence while locked at period 10 -> timeout when m reaches 21.
      do_reset("rst4");
      run_cycle(10, 0, oc6);
      run_cycle(10, 1, oc6);
      push(1, 7, 0, oc6 + 22);
      led_in = 2'b00;
      repeat (6) begin @(posedge clk); #1; end
      chk("t4_locked_after", int'(le1), 0);

      // Test 5: both LEDs rising while locked, then reset while locked.
      run_cycle(10, 1, oc6);
      push(1, 7, 0, cyc + 1);
      led_in = 2'b11;
      repeat (3) begin @(posedge clk); #1; end
      led_in = 2'b00;
      repeat (2) begin @(posedge clk); #1; end
      chk("t5_locked_after_11", int'(le1), 0);
      run_cycle(10, 1, oc6);
      chk("t5_locked_before_rst", int'(le1), 1);
      chk("t5_period_before_rst", int'(pr1), 10);
      rst = 1'b1;
      @(posedge clk); #1;
      check_zero("t5_rst");

      // Test 2: period 6 for 20 clean cycles, then a timeout at m=13.
      do_reset("rst2");
      run_cycle(6, 0, oc6);
      run_cycle(6, 1, oc6);
      for (int c = 0; c < 20; c++) run_cycle(6, 2, oc6);
      push(1, 7, 0, oc6 + 14);
      repeat (6) begin @(posedge clk); #1; end
      chk("t2_final_cc", int'(cc1), 20);
      chk("t2_final_cc_cw2", int'(cc2), 0);
      chk("end_pending_events", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
